// File: rtl/load_store_unit.sv
// Load/store unit: word-addressed memory port, sub-word extension, in-order store buffer with RMW drain.
// Optional STORE_FWD_EN: forward fully-covering buffered store data to matching loads.
module load_store_unit #(
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_uns,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        sb_empty,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, MERGE_WR} state_t;
    state_t state, state_nxt;

    logic [29:0]   sb_addr [SB_DEPTH];
    logic [31:0]   sb_data [SB_DEPTH];
    logic [3:0]    sb_mask [SB_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [31:0]   merge_q, merge_d;

    logic full, empty;
    assign full  = (count == CW'(SB_DEPTH));
    assign empty = (count == '0);

    logic        req_mis;
    logic [3:0]  req_mask;
    logic [31:0] req_sdata;

    always_comb begin
        req_mis   = 1'b0;
        req_mask  = 4'b1111;
        req_sdata = req_wdata;
        case (req_size)
            2'b00: begin
                req_mask  = 4'b0001 << req_addr[1:0];
                req_sdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_mis   = req_addr[0];
                req_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
                req_sdata = {2{req_wdata[15:0]}};
            end
            default: req_mis = (req_addr[1:0] != 2'b00);
        endcase
    end

    // Scan oldest to youngest so the last hit is the youngest matching store.
    logic          hit;
    logic [PW-1:0] idx;
`ifdef STORE_FWD_EN
    logic [3:0]    hit_mask;
    logic [31:0]   hit_data;
`endif

    always_comb begin
        hit = 1'b0;
        idx = head;
`ifdef STORE_FWD_EN
        hit_mask = '0;
        hit_data = '0;
`endif
        for (int unsigned k = 0; k < SB_DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count && sb_addr[idx] == req_addr[31:2]) begin
                hit = 1'b1;
`ifdef STORE_FWD_EN
                hit_mask = sb_mask[idx];
                hit_data = sb_data[idx];
`endif
            end
        end
    end

    logic fwd_ok, load_ok;
`ifdef STORE_FWD_EN
    assign fwd_ok = hit && ((hit_mask & req_mask) == req_mask);
`else
    assign fwd_ok = 1'b0;
`endif
    assign load_ok = (state == IDLE) && !full && (!hit || fwd_ok);

    logic [31:0] ld_word, ld_ext;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        ld_word = mem_RD;
`ifdef STORE_FWD_EN
        if (hit) ld_word = hit_data;
`endif
        case (req_addr[1:0])
            2'b00:   ld_b = ld_word[7:0];
            2'b01:   ld_b = ld_word[15:8];
            2'b10:   ld_b = ld_word[23:16];
            default: ld_b = ld_word[31:24];
        endcase
        ld_h = req_addr[1] ? ld_word[31:16] : ld_word[15:0];
        case (req_size)
            2'b00:   ld_ext = req_uns ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'b01:   ld_ext = req_uns ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ld_ext = ld_word;
        endcase
    end

    logic push, pop, load_acc, mis_acc;

    // Everything combinational is held quiet during reset so a pending RMW write is suppressed.
    always_comb begin
        req_ready = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        load_acc  = 1'b0;
        mis_acc   = 1'b0;
        mem_A     = '0;
        mem_WD    = '0;
        mem_WE    = 1'b0;
        state_nxt = state;
        merge_d   = merge_q;
        if (!rst) begin
            req_ready = req_mis ? 1'b1 : (req_we ? !full : load_ok);
            if (req_valid && req_ready) begin
                mis_acc  = req_mis;
                push     = req_we && !req_mis;
                load_acc = !req_we && !req_mis;
            end
            if (load_acc) begin
                mem_A = {req_addr[31:2], 2'b00};
            end else begin
                case (state)
                    IDLE: begin
                        if (!empty) begin
                            mem_A = {sb_addr[head], 2'b00};
                            if (sb_mask[head] == 4'b1111) begin
                                mem_WE = 1'b1;
                                mem_WD = sb_data[head];
                                pop    = 1'b1;
                            end else begin
                                for (int unsigned b = 0; b < 4; b++)
                                    merge_d[8*b +: 8] = sb_mask[head][b] ? sb_data[head][8*b +: 8]
                                                                         : mem_RD[8*b +: 8];
                                state_nxt = MERGE_WR;
                            end
                        end
                    end
                    MERGE_WR: begin
                        mem_A     = {sb_addr[head], 2'b00};
                        mem_WD    = merge_q;
                        mem_WE    = 1'b1;
                        pop       = 1'b1;
                        state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    assign sb_empty = rst || (empty && state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            merge_q     <= '0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            misalign    <= 1'b0;
        end else begin
            state   <= state_nxt;
            merge_q <= merge_d;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            rdata_valid <= load_acc;
            misalign    <= mis_acc;
            if (load_acc) rdata <= ld_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= req_addr[31:2];
            sb_data[tail] <= req_sdata;
            sb_mask[tail] <= req_mask;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
// Expected stall counts follow STORE_FWD_EN when the bench is built with it.
module tb_load_store_unit;
    localparam int SB_DEPTH = 4;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_we, req_uns;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rdata_valid, misalign, sb_empty, mem_WE;
    logic [31:0] rdata, mem_A, mem_WD, mem_RD;

    always #5 clk = ~clk;

    load_store_unit #(.SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .misalign(misalign), .sb_empty(sb_empty),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    logic [31:0] mem [64];
    assign mem_RD = mem[mem_A[7:2]];
    always @(posedge clk) if (mem_WE) mem[mem_A[7:2]] <= mem_WD;

    logic [31:0] wlog [$];
    always @(posedge clk) if (mem_WE) wlog.push_back(mem_A);

    int addr_err = 0;
    always @(negedge clk) if (mem_A[31:8] != 0 || mem_A[1:0] != 0) addr_err++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output int stalls);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        stalls = 0;
        while (!req_ready && stalls < 40) begin
            @(negedge clk);
            stalls++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp, input int exp_st);
        int st;
        issue(1'b0, size, uns, addr, 32'h0, st);
        check({tag, "_vld"}, 32'(rdata_valid), 32'd1);
        check(tag, rdata, exp);
        if (exp_st >= 0) check({tag, "_stall"}, 32'(st), 32'(exp_st));
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge clk);
        while (!sb_empty && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(sb_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st;
        foreach (mem[i]) mem[i] = '0;
        mem[6]  = 32'h0000_0030;
        mem[9]  = 32'h1122_3344;
        mem[12] = 32'hCAFE_F00D;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_rvalid", 32'(rdata_valid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mis", 32'(misalign), 32'd0);
        check("rst_empty", 32'(sb_empty), 32'd1);
        @(negedge clk);
        check("rst_we", 32'(mem_WE), 32'd0);
        check("rst_memA", mem_A, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // plain word load
        ld("lw18", 2'b10, 1'b0, 32'h18, 32'h0000_0030, 0);
        @(posedge clk); #1;
        check("lw18_vld_drop", 32'(rdata_valid), 32'd0);

        // byte store via read-modify-write
        issue(1'b1, 2'b00, 1'b0, 32'h18, 32'h0000_00FF, st);
        @(negedge clk);
        check("sb18_rd_we", 32'(mem_WE), 32'd0);
        check("sb18_rd_A", mem_A, 32'h18);
        @(negedge clk);
        check("sb18_wr_we", 32'(mem_WE), 32'd1);
        check("sb18_wr_A", mem_A, 32'h18);
        check("sb18_wr_WD", mem_WD, 32'h0000_00FF);
        @(posedge clk); #1;
        check("sb18_mem", mem[6], 32'h0000_00FF);
        check("sb18_empty", 32'(sb_empty), 32'd1);
        ld("lb18", 2'b00, 1'b0, 32'h18, 32'hFFFF_FFFF, 0);
        ld("lbu18", 2'b00, 1'b1, 32'h18, 32'h0000_00FF, 0);
        ld("lh18", 2'b01, 1'b0, 32'h18, 32'h0000_00FF, 0);
        ld("lb19", 2'b00, 1'b0, 32'h19, 32'h0000_0000, 0);

        // back-to-back word stores drain one per cycle in order
        wlog.delete();
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 2'b10, 1'b0, 32'h60 + 32'(4*k), 32'h1000_0000 + 32'(k), st);
            check("sw_stall", 32'(st), 32'd0);
        end
        wait_empty();
        check("sw_nwr", 32'(wlog.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < wlog.size()) check("sw_order", wlog[k], 32'h60 + 32'(4*k));
            check("sw_mem", mem[24+k], 32'h1000_0000 + 32'(k));
        end

        // byte stores outpace the RMW drain until the buffer is full
        wlog.delete();
        for (int k = 0; k < 6; k++) begin
            issue(1'b1, 2'b00, 1'b0, 32'h40 + 32'(4*k) + 32'(k % 4), 32'hA0 + 32'(k), st);
            check("sbf_stall", 32'(st), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h58; req_wdata = 32'h0;
        #1;
        check("full_st_rdy", 32'(req_ready), 32'd0);
        check("full_empty", 32'(sb_empty), 32'd0);
        req_we = 1'b0; req_addr = 32'h70;
        #1;
        check("full_ld_rdy", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        wait_empty();
        check("sbf_nwr", 32'(wlog.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < wlog.size()) check("sbf_order", wlog[k], 32'h40 + 32'(4*k));
            check("sbf_mem", mem[16+k], (32'hA0 + 32'(k)) << (8*(k % 4)));
        end

        // load hitting a buffered store
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, st);
        ld("lh22", 2'b01, 1'b0, 32'h22, 32'h0000_1234, FWD ? 0 : 1);
        wait_empty();
        check("sw20_mem", mem[8], 32'h1234_5678);
        issue(1'b1, 2'b00, 1'b0, 32'h25, 32'h0000_005A, st);
        ld("lw24_part", 2'b10, 1'b0, 32'h24, 32'h1122_5A44, 2);
        wait_empty();
        issue(1'b1, 2'b00, 1'b0, 32'h26, 32'h0000_0080, st);
        ld("lb26", 2'b00, 1'b0, 32'h26, 32'hFFFF_FF80, FWD ? 0 : 2);
        wait_empty();
        check("sb26_mem", mem[9], 32'h1180_5A44);
        ld("lbu26", 2'b00, 1'b1, 32'h26, 32'h0000_0080, 0);

        // misaligned requests are dropped
        wlog.delete();
        issue(1'b0, 2'b10, 1'b0, 32'h1A, 32'h0, st);
        check("mis_lw_pulse", 32'(misalign), 32'd1);
        check("mis_lw_vld", 32'(rdata_valid), 32'd0);
        @(posedge clk); #1;
        check("mis_lw_clr", 32'(misalign), 32'd0);
        issue(1'b1, 2'b01, 1'b0, 32'h19, 32'h0000_DEAD, st);
        check("mis_sh_pulse", 32'(misalign), 32'd1);
        @(negedge clk);
        check("mis_sh_empty", 32'(sb_empty), 32'd1);
        check("mis_sh_we", 32'(mem_WE), 32'd0);
        check("mis_mem", mem[6], 32'h0000_00FF);
        check("mis_nwr", 32'(wlog.size()), 32'd0);

        // reset while in MERGE_WR
        wlog.delete();
        issue(1'b1, 2'b00, 1'b0, 32'h30, 32'h0000_0077, st);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstm_we", 32'(mem_WE), 32'd0);
        check("rstm_empty", 32'(sb_empty), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rstm_empty2", 32'(sb_empty), 32'd1);
        check("rstm_rvalid", 32'(rdata_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("rstm_mem", mem[12], 32'hCAFE_F00D);
        check("rstm_nwr", 32'(wlog.size()), 32'd0);

        check("memA_align", 32'(addr_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
